// File: rtl/sw_word_loader.sv
// sw_word_loader: switch-driven byte loader that assembles a WIDTH-bit word and hands it out over valid/ready.
// Latency: a commit edge shows up on out_valid/out_word one cycle later; led follows writes/pointer moves in the same cycle.
// Backpressure: while a word is held (out_valid=1, out_ready=0) out_word is frozen and further commits are dropped, setting the sticky ovf flag.
//
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   sw[7:0]           - switch byte written on a rising edge of wr
//   wr, nxt, commit   - level inputs; only their rising edges act
//   out_ready         - consumer accepts out_word
//   out_word, out_valid - committed word and its valid flag
//   ptr               - selected byte index (0 = bits 7:0)
//   led[7:0]          - staging byte at ptr, from registers only
//   ovf               - sticky: a commit was dropped while the output was held
//
// Build option: define SWLOAD_AUTOINC_EN to advance ptr after every write.
module sw_word_loader #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           sw,
  input  logic                 wr,
  input  logic                 nxt,
  input  logic                 commit,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_word,
  output logic                 out_valid,
  output logic [((WIDTH/8) > 1 ? $clog2(WIDTH/8) : 1)-1:0] ptr,
  output logic [7:0]           led,
  output logic                 ovf
);

  localparam int NBYTES = WIDTH / 8;
  localparam int PW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Edge-history registers (reset to 1 so a level held through reset is not an edge)
  logic wr_hist_q,     wr_hist_d;
  logic nxt_hist_q,    nxt_hist_d;
  logic commit_hist_q, commit_hist_d;

  logic [WIDTH-1:0] stage_q,     stage_d;
  logic [PW-1:0]    ptr_q,       ptr_d;
  logic [WIDTH-1:0] out_word_q,  out_word_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q,       ovf_d;
  logic [7:0]       led_q,       led_d;
  state_t           state_q,     state_d;

  logic wr_edge;
  logic nxt_edge;
  logic commit_edge;
  logic advance;

  always_comb begin
    wr_edge       = wr     & ~wr_hist_q;
    nxt_edge      = nxt    & ~nxt_hist_q;
    commit_edge   = commit & ~commit_hist_q;
    wr_hist_d     = wr;
    nxt_hist_d    = nxt;
    commit_hist_d = commit;

    // Write lands at the current (old) pointer, before any advance this cycle
    stage_d = stage_q;
    if (wr_edge) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (ptr_q == PW'(i)) stage_d[i*8 +: 8] = sw;
      end
    end

`ifdef SWLOAD_AUTOINC_EN
    // wr and nxt together still move the pointer by exactly one
    advance = nxt_edge | wr_edge;
`else
    advance = nxt_edge;
`endif

    ptr_d = ptr_q;
    if (advance) begin
      if (ptr_q == PW'(NBYTES - 1)) ptr_d = '0;
      else                          ptr_d = ptr_q + PW'(1);
    end

    // led is registered from the next-state staging/pointer so it never
    // lags a write or pointer move and has no combinational path from sw
    led_d = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (ptr_d == PW'(i)) led_d = stage_d[i*8 +: 8];
    end

    // Output handshake; commits capture stage_q, i.e. the value before any
    // same-cycle write
    state_d    = state_q;
    out_word_d = out_word_q;
    ovf_d      = ovf_q;
    case (state_q)
      EMPTY: begin
        if (commit_edge) begin
          out_word_d = stage_q;
          state_d    = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (commit_edge) out_word_d = stage_q;
          else             state_d    = EMPTY;
        end else if (commit_edge) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d == FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_hist_q     <= 1'b1;
      nxt_hist_q    <= 1'b1;
      commit_hist_q <= 1'b1;
      stage_q       <= '0;
      ptr_q         <= '0;
      out_word_q    <= '0;
      out_valid_q   <= 1'b0;
      ovf_q         <= 1'b0;
      led_q         <= 8'h00;
      state_q       <= EMPTY;
    end else begin
      wr_hist_q     <= wr_hist_d;
      nxt_hist_q    <= nxt_hist_d;
      commit_hist_q <= commit_hist_d;
      stage_q       <= stage_d;
      ptr_q         <= ptr_d;
      out_word_q    <= out_word_d;
      out_valid_q   <= out_valid_d;
      ovf_q         <= ovf_d;
      led_q         <= led_d;
      state_q       <= state_d;
    end
  end

  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign ptr       = ptr_q;
  assign led       = led_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sw_word_loader.sv
// tb_sw_word_loader: directed bench for sw_word_loader at WIDTH=16 and WIDTH=32.
// Both instances share stimulus; each scenario checks the instance it targets.
// Expectations follow the build: SWLOAD_AUTOINC_EN changes pointer behaviour.
module tb_sw_word_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw;
  logic        wr, nxt, commit, out_ready;

  logic [15:0] ow16;
  logic        ov16, ovf16;
  logic [0:0]  ptr16;
  logic [7:0]  led16;

  logic [31:0] ow32;
  logic        ov32, ovf32;
  logic [1:0]  ptr32;
  logic [7:0]  led32;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  sw_word_loader #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .sw(sw), .wr(wr), .nxt(nxt), .commit(commit),
    .out_ready(out_ready), .out_word(ow16), .out_valid(ov16), .ptr(ptr16),
    .led(led16), .ovf(ovf16)
  );

  sw_word_loader #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .sw(sw), .wr(wr), .nxt(nxt), .commit(commit),
    .out_ready(out_ready), .out_word(ow32), .out_valid(ov32), .ptr(ptr32),
    .led(led32), .ovf(ovf32)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; sw = 8'h00; wr = 1'b0; nxt = 1'b0; commit = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press_wr(input logic [7:0] v);
    sw = v; wr = 1'b1; tick(); wr = 1'b0; tick();
  endtask

  task automatic press_nxt();
    nxt = 1'b1; tick(); nxt = 1'b0; tick();
  endtask

  task automatic press_commit();
    commit = 1'b1; tick(); commit = 1'b0; tick();
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (ow16 !== 16'h0000) $display("FAIL reset_out_word got=%h exp=0000", ow16); else pass_cnt++;
    chk_cnt++; if (ov16 !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", ov16); else pass_cnt++;
    chk_cnt++; if (ptr16 !== 1'b0) $display("FAIL reset_ptr got=%h exp=0", ptr16); else pass_cnt++;
    chk_cnt++; if (led16 !== 8'h00) $display("FAIL reset_led got=%h exp=00", led16); else pass_cnt++;
    chk_cnt++; if (ovf16 !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf16); else pass_cnt++;
  endtask

  task automatic test_basic_word();
    do_reset();
    press_wr(8'h34);
`ifndef SWLOAD_AUTOINC_EN
    press_nxt();
`endif
    chk_cnt++; if (ptr16 !== 1'b1) $display("FAIL basic_ptr_after_first got=%h exp=1", ptr16); else pass_cnt++;
    press_wr(8'h12);
    commit = 1'b1;
    // Before the commit edge is clocked nothing is valid yet
    chk_cnt++; if (ov16 !== 1'b0) $display("FAIL basic_valid_pre got=%b exp=0", ov16); else pass_cnt++;
    tick();
    commit = 1'b0;
    chk_cnt++; if (ov16 !== 1'b1) $display("FAIL basic_valid_post got=%b exp=1", ov16); else pass_cnt++;
    chk_cnt++; if (ow16 !== 16'h1234) $display("FAIL basic_out_word got=%h exp=1234", ow16); else pass_cnt++;
  endtask

  task automatic test_ptr_walk();
    logic [7:0] bytes [4];
    logic [1:0] exp_ptr;
    bytes[0] = 8'hC3; bytes[1] = 8'h5A; bytes[2] = 8'h7E; bytes[3] = 8'h81;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press_wr(bytes[i]);
`ifdef SWLOAD_AUTOINC_EN
      chk_cnt++; if (ptr32 !== 2'(i + 1)) $display("FAIL walk_autoinc_ptr i=%0d got=%0d exp=%0d", i, ptr32, (i + 1) % 4); else pass_cnt++;
`else
      chk_cnt++; if (led32 !== bytes[i]) $display("FAIL walk_led_write i=%0d got=%h exp=%h", i, led32, bytes[i]); else pass_cnt++;
      press_nxt();
`endif
    end
    chk_cnt++; if (led32 !== bytes[0]) $display("FAIL walk_led_wrapped got=%h exp=%h", led32, bytes[0]); else pass_cnt++;
    exp_ptr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      press_nxt();
      exp_ptr = exp_ptr + 2'd1;
      chk_cnt++; if (ptr32 !== exp_ptr) $display("FAIL walk_ptr step=%0d got=%0d exp=%0d", i, ptr32, exp_ptr); else pass_cnt++;
      chk_cnt++; if (led32 !== bytes[exp_ptr]) $display("FAIL walk_led step=%0d got=%h exp=%h", i, led32, bytes[exp_ptr]); else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    press_wr(8'h34);
    press_commit();
    chk_cnt++; if (ow16 !== 16'h0034) $display("FAIL ovf_first_word got=%h exp=0034", ow16); else pass_cnt++;
    press_wr(8'h99);
    press_commit();
    chk_cnt++; if (ow16 !== 16'h0034) $display("FAIL ovf_word_held got=%h exp=0034", ow16); else pass_cnt++;
    chk_cnt++; if (ovf16 !== 1'b1) $display("FAIL ovf_set got=%b exp=1", ovf16); else pass_cnt++;
    chk_cnt++; if (ov16 !== 1'b1) $display("FAIL ovf_still_valid got=%b exp=1", ov16); else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_cnt++; if (ov16 !== 1'b0) $display("FAIL ovf_drain_valid got=%b exp=0", ov16); else pass_cnt++;
    chk_cnt++; if (ovf16 !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", ovf16); else pass_cnt++;
    chk_cnt++; if (ow16 !== 16'h0034) $display("FAIL ovf_word_after_drain got=%h exp=0034", ow16); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_word;
    do_reset();
    press_wr(8'h56);
    press_commit();
    press_wr(8'h78);
`ifdef SWLOAD_AUTOINC_EN
    exp_word = 16'h7856;
`else
    exp_word = 16'h0078;
`endif
    out_ready = 1'b1; commit = 1'b1;
    tick();
    commit = 1'b0;
    chk_cnt++; if (ov16 !== 1'b1) $display("FAIL b2b_valid got=%b exp=1", ov16); else pass_cnt++;
    chk_cnt++; if (ow16 !== exp_word) $display("FAIL b2b_word got=%h exp=%h", ow16, exp_word); else pass_cnt++;
    tick();
    out_ready = 1'b0;
    chk_cnt++; if (ov16 !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", ov16); else pass_cnt++;
    chk_cnt++; if (ovf16 !== 1'b0) $display("FAIL b2b_no_ovf got=%b exp=0", ovf16); else pass_cnt++;

    // Commit and write in the same cycle: the committed word is the pre-write staging
    do_reset();
    press_wr(8'h11);
    sw = 8'h22; wr = 1'b1; commit = 1'b1;
    tick();
    wr = 1'b0; commit = 1'b0;
    tick();
    chk_cnt++; if (ow16 !== 16'h0011) $display("FAIL commit_prewrite got=%h exp=0011", ow16); else pass_cnt++;
  endtask

  task automatic test_wr_held_reset();
    reset = 1'b1; sw = 8'h5A; wr = 1'b1; nxt = 1'b0; commit = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk_cnt++; if (led16 !== 8'h00) $display("FAIL held_no_write_led got=%h exp=00", led16); else pass_cnt++;
    chk_cnt++; if (ptr16 !== 1'b0) $display("FAIL held_no_write_ptr got=%h exp=0", ptr16); else pass_cnt++;
    wr = 1'b0; tick();
    wr = 1'b1; tick();
    sw = 8'hFF;           // changes while held must not be written
    tick(); tick();
    wr = 1'b0; tick();
`ifdef SWLOAD_AUTOINC_EN
    chk_cnt++; if (ptr16 !== 1'b1) $display("FAIL held_one_write_ptr got=%h exp=1", ptr16); else pass_cnt++;
`else
    chk_cnt++; if (led16 !== 8'h5A) $display("FAIL held_one_write_led got=%h exp=5a", led16); else pass_cnt++;
`endif
    press_commit();
    chk_cnt++; if (ow16 !== 16'h005A) $display("FAIL held_one_write_word got=%h exp=005a", ow16); else pass_cnt++;
  endtask

  task automatic test_autoinc_mode();
    do_reset();
    press_wr(8'hAA);
    press_wr(8'hBB);
    press_commit();
`ifdef SWLOAD_AUTOINC_EN
    chk_cnt++; if (ow16 !== 16'hBBAA) $display("FAIL autoinc_word got=%h exp=bbaa", ow16); else pass_cnt++;
    chk_cnt++; if (ptr16 !== 1'b0) $display("FAIL autoinc_ptr got=%h exp=0", ptr16); else pass_cnt++;
    // wr and nxt together advance exactly once
    sw = 8'hCC; wr = 1'b1; nxt = 1'b1; tick(); wr = 1'b0; nxt = 1'b0; tick();
    chk_cnt++; if (ptr16 !== 1'b1) $display("FAIL autoinc_wr_nxt_ptr got=%h exp=1", ptr16); else pass_cnt++;
`else
    chk_cnt++; if (ow16 !== 16'h00BB) $display("FAIL noinc_word got=%h exp=00bb", ow16); else pass_cnt++;
    chk_cnt++; if (ptr16 !== 1'b0) $display("FAIL noinc_ptr got=%h exp=0", ptr16); else pass_cnt++;
    // wr and nxt together: write at old ptr, then advance
    sw = 8'hCC; wr = 1'b1; nxt = 1'b1; tick(); wr = 1'b0; nxt = 1'b0; tick();
    chk_cnt++; if (ptr16 !== 1'b1) $display("FAIL noinc_wr_nxt_ptr got=%h exp=1", ptr16); else pass_cnt++;
    press_nxt();
    chk_cnt++; if (led16 !== 8'hCC) $display("FAIL noinc_wr_nxt_byte got=%h exp=cc", led16); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_priority();
    do_reset();
    press_wr(8'h34);
    press_nxt();
    press_commit();
    press_commit();   // dropped: sets ovf while FULL
    chk_cnt++; if (ovf16 !== 1'b1) $display("FAIL prio_setup_ovf got=%b exp=1", ovf16); else pass_cnt++;
    reset = 1'b1; wr = 1'b1; nxt = 1'b1; commit = 1'b1; out_ready = 1'b1; sw = 8'h77;
    tick();
    reset = 1'b0; wr = 1'b0; nxt = 1'b0; commit = 1'b0; out_ready = 1'b0;
    tick();
    chk_cnt++; if (ov16 !== 1'b0) $display("FAIL prio_valid got=%b exp=0", ov16); else pass_cnt++;
    chk_cnt++; if (ow16 !== 16'h0000) $display("FAIL prio_word got=%h exp=0000", ow16); else pass_cnt++;
    chk_cnt++; if (ovf16 !== 1'b0) $display("FAIL prio_ovf got=%b exp=0", ovf16); else pass_cnt++;
    chk_cnt++; if (ptr16 !== 1'b0) $display("FAIL prio_ptr got=%h exp=0", ptr16); else pass_cnt++;
    chk_cnt++; if (led16 !== 8'h00) $display("FAIL prio_led got=%h exp=00", led16); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; sw = 8'h00; wr = 1'b0; nxt = 1'b0; commit = 1'b0; out_ready = 1'b0;
    tick();
    test_reset();
    test_basic_word();
    test_ptr_walk();
    test_overflow();
    test_back_to_back();
    test_wr_held_reset();
    test_autoinc_mode();
    test_reset_priority();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sw_word_loader.md
SW_WORD_LOADER -- requirements
Module: sw_word_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, staging/output word width; legal values are multiples of 8 from 16 to 64.
REQ-002 SHALL derive NBYTES = WIDTH/8 and PW = max(1, clog2(NBYTES)) internally.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sw, input, 8, switch byte to be written.
REQ-006 SHALL have port wr, input, 1, level; its rising edge writes sw into the selected byte.
REQ-007 SHALL have port nxt, input, 1, level; its rising edge advances the byte pointer.
REQ-008 SHALL have port commit, input, 1, level; its rising edge requests transfer of the staging word to the output.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts out_word.
REQ-010 SHALL have port out_word, output, WIDTH, committed word.
REQ-011 SHALL have port out_valid, output, 1, out_word holds an unaccepted word.
REQ-012 SHALL have port ptr, output, PW, index of the selected byte (0 = bits 7:0).
REQ-013 SHALL have port led, output, 8, staging byte at ptr, driven from registers only.
REQ-014 SHALL have port ovf, output, 1, sticky flag: a commit was dropped.

Function
REQ-015 SHALL detect edges as (level & ~level_q) per input, with one history register per input; an edge acts in the cycle it is detected.
REQ-016 SHALL, on a wr edge, write sw into staging bits [8*ptr+7 : 8*ptr] and leave all other bytes unchanged.
REQ-017 SHALL, on an nxt edge, set ptr to ptr+1, wrapping from NBYTES-1 to 0.
REQ-018 SHALL, on simultaneous wr and nxt edges, write at the old ptr, then advance.
REQ-019 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 SHALL, in EMPTY on a commit edge, load out_word with the staging value present before any same-cycle write, and enter FULL next cycle (1-cycle latency).
REQ-021 SHALL, in FULL with out_ready=1 and no commit edge, return to EMPTY next cycle; out_word holds its value.
REQ-022 SHALL, in FULL with out_ready=1 and a commit edge in the same cycle, load the new word and remain FULL.
REQ-023 SHALL, in FULL with out_ready=0 and a commit edge, drop the commit, keep out_word, and set ovf.
REQ-024 SHALL hold out_word stable while out_valid=1 and out_ready=0.
REQ-025 SHALL keep led equal to the selected staging byte after every write or pointer change, with no combinational path from sw.

Reset
REQ-026 SHALL, on reset, clear staging, out_word, out_valid, ptr and ovf to 0, and enter EMPTY.
REQ-027 SHALL load all edge-history registers with 1 on reset, so an input held through reset produces no edge until it is released and pressed again.
REQ-028 SHALL give reset priority over every edge event in the same cycle, including a mid-handshake FULL state.

Configuration
REQ-029 SHALL, with SWLOAD_AUTOINC_EN defined, advance ptr (with wrap) on every wr edge after the write; simultaneous wr and nxt edges advance ptr by exactly one.
REQ-030 SHALL, without SWLOAD_AUTOINC_EN, change ptr only on nxt edges and reset.

Verification
REQ-031 SHALL cover: WIDTH=16, sw=0x34 then wr; nxt; sw=0x12 then wr; commit -> out_word=0x1234 and out_valid=1 one cycle after the commit edge.
REQ-032 SHALL cover: WIDTH=32, four nxt edges -> ptr reads 1,2,3,0; led tracks each staging byte.
REQ-033 SHALL cover: FULL with out_ready=0, second commit -> out_word unchanged, ovf=1; then out_ready=1 -> out_valid=0 next cycle, ovf still 1.
REQ-034 SHALL cover: FULL with out_ready=1 and a commit edge in the same cycle -> out_valid stays 1 and out_word takes the new staging value.
REQ-035 SHALL cover: wr held high across reset deassert -> no write; release and re-press wr -> exactly one write.
REQ-036 SHALL cover: with SWLOAD_AUTOINC_EN, WIDTH=16, wr 0xAA then wr 0xBB -> staging=0xBBAA and ptr=0.
